uart_tx_arbiter: RTL and testbench

//  Shares the single UART TX byte port (debug link to PC) between N byte-stream requesters
//  (e.g. periodic heartbeat, eth link status, debug dump). Round-robin arbitration at frame level.
//  A granted requester owns the port until it sends a byte flagged last, or until it stalls.

---
 rtl/uart_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART TX byte port between N byte-stream requesters. Arbitration
// is round-robin at frame granularity: once a requester is granted it owns
// the port until it hands over a byte flagged last, or until it stalls
// mid-frame for TIMEOUT counted cycles. A single-byte output register sits
// between the winning requester and the UART.
//
// Handshake semantics (both sides): a byte moves on a rising clock edge
// exactly when valid and ready are both high in the cycle before it. A source
// holding valid with ready low keeps its byte and last flag stable. On the
// UART side o_wvalid/o_wdata stay stable until i_wready.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active low
//   i_req_valid  [N]   requester k offers i_req_data[8k+7:8k]
//   i_req_data   [8N]  packed requester bytes
//   i_req_last   [N]   offered byte ends the requester's frame
//   o_req_ready  [N]   byte of requester k accepted when valid & ready
//   o_wdata      [8]   byte towards the UART
//   o_wvalid           o_wdata holds a byte
//   i_wready           UART takes the byte (transfer = o_wvalid & i_wready)
//   o_grant      [N]   one-hot current owner, zero when idle
//   o_busy             a frame is in progress; this is the FSM state bit
//   o_timeout          one-cycle pulse when a stalled owner loses its grant
//
// Parameters
//   N        number of requesters, 2..8
//   TIMEOUT  stalled cycles tolerated mid-frame; 0 disables revocation
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req_valid,
    input  logic [8*N-1:0] i_req_data,
    input  logic [N-1:0]   i_req_last,
    output logic [N-1:0]   o_req_ready,
    output logic [7:0]     o_wdata,
    output logic           o_wvalid,
    input  logic           i_wready,
    output logic [N-1:0]   o_grant,
    output logic           o_busy,
    output logic           o_timeout
);

    localparam int PW = $clog2(N);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] STALL_LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;      // last owner; search starts one past it
    logic [PW-1:0] gidx_q, gidx_d;    // index of current owner
    logic [N-1:0]  grant_q, grant_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wvalid_q, wvalid_d;
    logic          timeout_q, timeout_d;

    logic          out_free;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          accept;

    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW:0]   cand;

    // The output register can take a new byte when empty or when its
    // current byte leaves this very cycle.
    assign out_free = !wvalid_q || i_wready;

    assign g_valid  = i_req_valid[gidx_q];
    assign g_last   = i_req_last[gidx_q];
    assign g_data   = i_req_data[{gidx_q, 3'b000} +: 8];
    assign accept   = (state_q == SEND) && g_valid && out_free;

    // Round-robin search: first valid requester at ptr+1, ptr+2, ... mod N.
    // cand carries one spare bit so ptr+i never overflows before the wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!pick_found && i_req_valid[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        stall_d     = stall_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        timeout_d   = 1'b0;
        o_req_ready = '0;

        // A byte leaving the register empties it unless refilled below.
        if (wvalid_q && i_wready) begin
            wvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = SEND;
                    gidx_d  = pick_idx;
                    grant_d = N'(1) << pick_idx;
                    stall_d = '0;
                end
            end

            SEND: begin
                o_req_ready[gidx_q] = out_free;
                if (accept) begin
                    wdata_d  = g_data;
                    wvalid_d = 1'b1;
                    stall_d  = '0;
                    if (g_last) begin
                        // Frame ends; the byte still drains from the register.
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = gidx_q;
                    end
                end else if (out_free && !g_valid && (TIMEOUT != 0)) begin
                    // Only owner-side stalls count; UART backpressure does not.
                    if (stall_q == STALL_LIMIT) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        ptr_d     = gidx_q;
                        stall_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        stall_d = stall_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(N - 1);
            gidx_q    <= '0;
            grant_q   <= '0;
            stall_q   <= '0;
            wdata_q   <= '0;
            wvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            stall_q   <= stall_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_wdata   = wdata_q;
    assign o_wvalid  = wvalid_q;
    assign o_grant   = grant_q;
    assign o_busy    = (state_q == SEND);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Requesters are fed from per-requester frame lists. Before a phase starts a
// frame-level round-robin model turns the lists into the expected owner order
// and byte stream (owner_q, exp_q). A monitor on the falling edge pops and
// compares whenever a byte leaves on the UART side or a new grant appears.
// Directed sections cover reset, backpressure, stall timeout and reset
// mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic [N-1:0]   i_req_valid = '0;
    logic [8*N-1:0] i_req_data  = '0;
    logic [N-1:0]   i_req_last  = '0;
    logic           i_wready    = 1'b0;
    logic [N-1:0]   o_req_ready;
    logic [7:0]     o_wdata;
    logic           o_wvalid;
    logic [N-1:0]   o_grant;
    logic           o_busy;
    logic           o_timeout;

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_wdata     (o_wdata),
        .o_wvalid    (o_wvalid),
        .i_wready    (i_wready),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    // ---------------- bench state ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         owner_q[$];

    logic [7:0] data_mem [N][64];
    bit         last_mem [N][64];
    int         byte_cnt [N];
    int         head     [N];
    int         gap      [N];
    int         fr_cnt   [N];
    int         fr_start [N][16];
    int         fr_len   [N][16];

    bit         drv_en     = 1'b0;
    bit         rand_gaps  = 1'b0;
    bit         rand_wr    = 1'b0;
    bit         timeout_ok = 1'b0;
    int         lo_after   = 1000000;
    int         low_left   = 0;
    int         xfer_total = 0;
    logic [N-1:0] fire_s   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_frames();
        for (int k = 0; k < N; k++) begin
            byte_cnt[k] = 0;
            head[k]     = 0;
            gap[k]      = 0;
            fr_cnt[k]   = 0;
        end
    endtask

    task automatic add_frame(input int k, input int len, input logic [7:0] base, input bit rnd);
        fr_start[k][fr_cnt[k]] = byte_cnt[k];
        fr_len[k][fr_cnt[k]]   = len;
        fr_cnt[k]++;
        for (int i = 0; i < len; i++) begin
            data_mem[k][byte_cnt[k]] = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
            last_mem[k][byte_cnt[k]] = (i == len - 1);
            byte_cnt[k]++;
        end
    endtask

    // Frame-level reference: after reset the last owner is N-1; each frame
    // goes to the first requester with frames left, searching from one past
    // the previous owner. Its bytes appear contiguously on the UART.
    task automatic build_expected();
        int  nf [N];
        int  last_own;
        int  own;
        int  c;
        bit  more;
        for (int k = 0; k < N; k++) nf[k] = 0;
        last_own = N - 1;
        more = 1'b1;
        while (more) begin
            own = -1;
            for (int i = 1; i <= N; i++) begin
                c = (last_own + i) % N;
                if (own < 0 && nf[c] < fr_cnt[c]) own = c;
            end
            if (own < 0) begin
                more = 1'b0;
            end else begin
                owner_q.push_back(own);
                for (int b = 0; b < fr_len[own][nf[own]]; b++)
                    exp_q.push_back(data_mem[own][fr_start[own][nf[own]] + b]);
                nf[own]++;
                last_own = own;
            end
        end
    endtask

    task automatic start_phase(input bit rg, input bit rw, input int la, input int ll);
        build_expected();
        rand_gaps  = rg;
        rand_wr    = rw;
        lo_after   = la;
        low_left   = ll;
        xfer_total = 0;
        drv_en     = 1'b1;
    endtask

    // Requesters present their head byte; a frame's first byte is always
    // offered so arbitration sees every requester with work pending.
    task automatic drive_update();
        bit v;
        bit at_start;
        for (int k = 0; k < N; k++) begin
            if (fire_s[k]) begin
                head[k]++;
                gap[k] = 0;
            end
            if (head[k] < byte_cnt[k]) begin
                at_start = 1'b1;
                if (head[k] > 0) at_start = last_mem[k][head[k] - 1];
                if (at_start || !rand_gaps || gap[k] >= 6) v = 1'b1;
                else v = ($urandom_range(0, 3) != 0);
                gap[k] = v ? 0 : gap[k] + 1;
                i_req_valid[k]        = v;
                i_req_data[k*8 +: 8]  = data_mem[k][head[k]];
                i_req_last[k]         = last_mem[k][head[k]];
            end else begin
                i_req_valid[k]        = 1'b0;
                i_req_data[k*8 +: 8]  = 8'h00;
                i_req_last[k]         = 1'b0;
            end
        end
        if (low_left > 0 && xfer_total >= lo_after) begin
            i_wready = 1'b0;
            low_left--;
        end else if (rand_wr) begin
            i_wready = ($urandom_range(0, 9) < 7);
        end else begin
            i_wready = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (drv_en) drive_update();
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [N-1:0] prev_grant     = '0;
    bit           prev_last_fire = 1'b0;

    initial begin
        logic [7:0] e;
        int         own;
        forever begin
            @(negedge i_clk);
            fire_s = i_req_valid & o_req_ready;
            if (o_wvalid && i_wready && i_rst) begin
                xfer_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, o_wdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {24'h0, o_wdata}, {24'h0, e});
                end
            end
            if (prev_grant == '0 && o_grant != '0) begin
                if (owner_q.size() == 0) begin
                    check("unexpected_grant", 32'(o_grant), 32'h0);
                end else begin
                    own = owner_q.pop_front();
                    check("grant_owner", 32'(o_grant), 32'(1) << own);
                end
            end
            if (prev_last_fire) begin
                check("idle_after_last_grant", 32'(o_grant), 32'h0);
                check("idle_after_last_busy", 32'(o_busy), 32'h0);
            end
            if (o_req_ready & ~o_grant) check("ready_outside_grant", 32'(o_req_ready), 32'h0);
            if ($countones(o_grant) > 1) check("grant_onehot", 32'(o_grant), 32'h0);
            if (!timeout_ok && o_timeout) check("spurious_timeout", 32'(o_timeout), 32'h0);
            prev_last_fire = i_rst && (|(i_req_valid & o_req_ready & i_req_last));
            prev_grant     = o_grant;
        end
    end

    // ---------------- phase control ----------------
    task automatic do_reset();
        drv_en      = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        i_wready    = 1'b0;
        i_rst       = 1'b0;
        repeat (2) @(negedge i_clk);
        exp_q.delete();
        owner_q.delete();
        clear_frames();
        timeout_ok = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
            done = (exp_q.size() == 0) && (owner_q.size() == 0);
            for (int k = 0; k < N; k++) if (head[k] < byte_cnt[k]) done = 1'b0;
        end
        if (!done) fail_now("phase_drain");
        repeat (3) @(negedge i_clk);
        drv_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  w;
        int  n;
        bit  seen;

        // 1: reset with every requester valid
        i_rst       = 1'b0;
        i_req_valid = '1;
        i_req_data  = 24'h33_22_11;
        i_req_last  = '1;
        i_wready    = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_wvalid", 32'(o_wvalid), 32'h0);
        check("rst_wdata", 32'(o_wdata), 32'h0);
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_ready", 32'(o_req_ready), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_timeout", 32'(o_timeout), 32'h0);

        // 2: single two-byte frame from requester 0
        do_reset();
        add_frame(0, 2, 8'h48, 1'b0);
        start_phase(1'b0, 1'b0, 1000000, 0);
        wait_done(40);

        // 3: round robin between requesters 0 and 1
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_frame(0, 2, 8'h10 + 8'(2*f), 1'b0);
            add_frame(1, 2, 8'h20 + 8'(2*f), 1'b0);
        end
        start_phase(1'b0, 1'b0, 1000000, 0);
        wait_done(100);

        // 4: UART backpressure longer than TIMEOUT must not revoke
        do_reset();
        add_frame(2, 4, 8'hA0, 1'b0);
        start_phase(1'b0, 1'b0, 0, 20);
        for (int j = 0; j < 20; j++) begin
            @(negedge i_clk);
            if (j >= 2) begin
                check("bp_wvalid", 32'(o_wvalid), 32'h1);
                check("bp_wdata", 32'(o_wdata), 32'hA0);
                check("bp_ready", 32'(o_req_ready), 32'h0);
                check("bp_timeout", 32'(o_timeout), 32'h0);
            end
        end
        wait_done(60);

        // 5: stall timeout, pending requester 0 gets the port next
        do_reset();
        timeout_ok = 1'b1;
        owner_q.push_back(1);
        owner_q.push_back(0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h5A);
        i_req_valid = 3'b010;
        i_req_data  = 24'h00_11_00;
        i_req_last  = 3'b000;
        i_wready    = 1'b1;
        w = 0;
        while (!(i_req_valid[1] && o_req_ready[1]) && w < 10) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 10) fail_now("to_first_accept");
        @(posedge i_clk);
        #1;
        i_req_valid = 3'b001;
        i_req_data  = 24'h00_00_5A;
        i_req_last  = 3'b001;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge i_clk);
            n++;
            if (o_timeout) seen = 1'b1;
        end
        check("timeout_latency", 32'(n), 32'(TO + 1));
        check("timeout_grant_cleared", 32'(o_grant), 32'h0);
        check("timeout_busy_cleared", 32'(o_busy), 32'h0);
        @(negedge i_clk);
        check("timeout_single_pulse", 32'(o_timeout), 32'h0);
        check("grant_after_timeout", 32'(o_grant), 32'h1);
        @(posedge i_clk);
        #1;
        i_req_valid = '0;
        wait_done(40);
        timeout_ok = 1'b0;

        // 6: reset while the third byte waits in the output register
        do_reset();
        add_frame(1, 5, 8'hC0, 1'b0);
        start_phase(1'b0, 1'b0, 2, 1000);
        w = 0;
        while (!(xfer_total >= 2 && i_wready == 1'b0) && w < 30) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 30) fail_now("mid_frame_setup");
        check("mid_held_wvalid", 32'(o_wvalid), 32'h1);
        check("mid_held_wdata", 32'(o_wdata), 32'hC2);
        drv_en = 1'b0;
        i_rst  = 1'b0;
        @(negedge i_clk);
        check("mid_rst_wvalid", 32'(o_wvalid), 32'h0);
        check("mid_rst_grant", 32'(o_grant), 32'h0);
        check("mid_rst_busy", 32'(o_busy), 32'h0);
        do_reset();
        add_frame(0, 2, 8'hD0, 1'b0);
        add_frame(1, 1, 8'hE0, 1'b0);
        start_phase(1'b0, 1'b0, 1000000, 0);
        wait_done(60);

        // randomized phases: random frames, gaps and UART backpressure
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                n = $urandom_range(0, 4);
                for (int f = 0; f < n; f++) add_frame(k, $urandom_range(1, 5), 8'h00, 1'b1);
            end
            start_phase(1'b1, 1'b1, 1000000, 0);
            wait_done(1500);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
